rst_release_seq: RTL and testbench
==================================

RST_RELEASE_SEQ -- requirements
Module: rst_release_seq

Interface
REQ-001 Parameter NUM_STAGES, default 4: number of sequenced reset domains, legal range 1..16.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles all domains stay in reset after entry to hold, legal range 1..65535.
REQ-003 Parameter STAGE_GAP, default 8: minimum cycles between consecutive domain releases, legal range 1..65535.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rstn_sys  in  1  synchronous, active-low block reset; sampled only on clk rising edge.
REQ-006 sw_rst_req  in  1  level software reset request; held high until sw_rst_ack is seen.
REQ-007 stage_ok  in  NUM_STAGES  per-domain release permission (e.g. PLL lock); bit k gates release of domain k.
REQ-008 rstn_dom  out  NUM_STAGES  active-low domain resets; bit k feeds domain k, and 0 means the domain is in reset.
REQ-009 sw_rst_ack  out  1  one-cycle acknowledge pulse for an accepted sw_rst_req.
REQ-010 rst_done  out  1  high when all domains are released.

Function
REQ-011 FSM states SHALL be S_HOLD, S_STAGE and S_DONE, with all outputs registered.
REQ-012 S_HOLD SHALL drive rstn_dom all 0 and count HOLD_CYCLES cycles, then enter S_STAGE with stage index 0.
REQ-013 S_STAGE, domain 0 SHALL release on the HOLD_CYCLES-th edge in hold if stage_ok[0]=1; otherwise on the first later edge where stage_ok[0]=1.
REQ-014 S_STAGE, domain k (k≥1) SHALL release on the STAGE_GAP-th edge after domain k-1 released if stage_ok[k]=1; otherwise on the first later edge where stage_ok[k]=1.
REQ-015 The gap counter SHALL saturate while waiting on stage_ok and SHALL not wrap.
REQ-016 Releases SHALL be strictly in ascending index order, one domain per edge at most.
REQ-017 Released bits SHALL be sticky; stage_ok falling after release SHALL have no effect.
REQ-018 On the edge that releases domain NUM_STAGES-1, the FSM SHALL enter S_DONE; rst_done and rstn_dom[NUM_STAGES-1] SHALL rise on the same edge.
REQ-019 sw_rst_req is accepted on a rising request level (previous sampled 0, current 1) in any state.
REQ-020 On acceptance: next edge rstn_dom SHALL be all 0, rst_done 0, sw_rst_ack 1 for exactly one cycle, state S_HOLD, and counters cleared.
REQ-021 An accepted request during S_HOLD or S_STAGE SHALL restart the hold count from 0.
REQ-022 sw_rst_req held high after ack SHALL be ignored until it is sampled low at least once.
REQ-023 Counter width SHALL be $clog2(max(HOLD_CYCLES,STAGE_GAP)+1); comparisons SHALL be exact-equal, with no overflow.
REQ-024 NUM_STAGES=1: only REQ-013 applies and rst_done rises with rstn_dom[0].

Reset
REQ-025 rstn_sys=0 at an edge SHALL set state S_HOLD, counters 0, request history 0, rstn_dom all 0, sw_rst_ack 0 and rst_done 0, with effect on that edge.
REQ-026 Reset mid-sequence or in S_DONE SHALL abort immediately per REQ-025, with no partial release retained.
REQ-027 The hold count SHALL begin on the first edge with rstn_sys=1 (edge 1).
REQ-028 sw_rst_req high during rstn_sys=0 SHALL NOT be acknowledged.
REQ-029 That request SHALL be acknowledged only after it is seen low once following reset release.

Structure
REQ-030 Package rst_seq_pkg SHALL hold the FSM state enum and the default HOLD_CYCLES/STAGE_GAP/NUM_STAGES constants.
REQ-031 One sub-module rst_seq_cnt SHALL be used for both hold and gap counting.
REQ-032 rst_seq_cnt SHALL be a parameterised-width up-counter with clear, enable, saturate and terminal-match output.
REQ-033 Elaboration SHALL fail on out-of-range parameters.

Verification
REQ-034 Defaults, stage_ok=4'b1111, rstn_sys released at edge 0 -> rstn_dom bits rise after edges 16/24/32/40, and rst_done rises after edge 40.
REQ-035 stage_ok[2]=0 until edge 50 -> rstn_dom[2] rises after edge 50, rstn_dom[3] after edge 58, and rst_done after edge 58.
REQ-036 In S_DONE pulse sw_rst_req high for 5 cycles -> one ack pulse, rstn_dom=0 next edge, and the sequence repeats with the same 16/24/32/40 offsets.
REQ-037 sw_rst_req rises at edge 28 (domains 0,1 released) -> all domains are reasserted at edge 29 and the hold restarts, so domain 0 releases 16 edges later.
REQ-038 rstn_sys=0 at edge 30 for 1 cycle -> all outputs are 0 at edge 30 and the release sequence restarts from edge 31.
REQ-039 NUM_STAGES=1, HOLD_CYCLES=1 -> rstn_dom[0] and rst_done rise on edge 1.
REQ-040 In the same bench, sw_rst_req held high through reset -> no ack until the request is toggled.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and defaults for the staged reset-release sequencer.
// Holds the FSM encoding and the counter-width helper used by the top.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    S_HOLD  = 2'd0,
    S_STAGE = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  localparam int DEF_NUM_STAGES  = 4;
  localparam int DEF_HOLD_CYCLES = 16;
  localparam int DEF_STAGE_GAP   = 8;

  // Wide enough to hold the larger of the two terminal counts exactly.
  function automatic int cnt_width(input int hold, input int gap);
    return $clog2(((hold > gap) ? hold : gap) + 1);
  endfunction

endpackage

// File: rtl/rst_seq_cnt.sv
// Saturating up-counter shared by the hold and inter-stage gap phases.
// hit is high on the edge that completes 'target' counts and stays high while saturated.
module rst_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] target,
  output logic         hit
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != target)) begin
      cnt <= cnt + W'(1);
    end
  end

  // cnt == target-1 means this edge is the target-th one; cnt == target means we waited past it.
  assign hit = (cnt == (target - W'(1))) || (cnt == target);

endmodule

// File: rtl/rst_release_seq.sv
// Releases NUM_STAGES reset domains in ascending order after a hold period, gated per domain by stage_ok.
// A rising sw_rst_req re-enters hold and emits a one-cycle ack; all outputs are registered.
module rst_release_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_STAGES  = DEF_NUM_STAGES,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int STAGE_GAP   = DEF_STAGE_GAP
) (
  input  logic                  clk,
  input  logic                  rstn_sys,
  input  logic                  sw_rst_req,
  input  logic [NUM_STAGES-1:0] stage_ok,
  output logic [NUM_STAGES-1:0] rstn_dom,
  output logic                  sw_rst_ack,
  output logic                  rst_done
);

  if (NUM_STAGES < 1 || NUM_STAGES > 16) begin : g_bad_stages
    $error("rst_release_seq: NUM_STAGES must be 1..16");
  end
  if (HOLD_CYCLES < 1 || HOLD_CYCLES > 65535) begin : g_bad_hold
    $error("rst_release_seq: HOLD_CYCLES must be 1..65535");
  end
  if (STAGE_GAP < 1 || STAGE_GAP > 65535) begin : g_bad_gap
    $error("rst_release_seq: STAGE_GAP must be 1..65535");
  end

  localparam int CW = cnt_width(HOLD_CYCLES, STAGE_GAP);
  localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_STAGES - 1);
  localparam logic [CW-1:0] HOLD_T   = CW'(HOLD_CYCLES);
  localparam logic [CW-1:0] GAP_T    = CW'(STAGE_GAP);

  state_t                  state_q, state_nxt;
  logic [IW-1:0]           idx_q, idx_nxt;
  logic                    req_armed_q;
  logic [NUM_STAGES-1:0]   dom_nxt;
  logic                    done_nxt;
  logic                    ack_nxt;
  logic                    accept;
  logic                    release_now;
  logic                    cnt_hit;
  logic                    cnt_clr;
  logic                    cnt_en;
  logic [CW-1:0]           cnt_target;

  // Armed only after the request has been sampled low outside reset, so a level
  // held through reset or past an ack cannot retrigger.
  assign accept = sw_rst_req & req_armed_q;

  always_comb begin
    release_now = 1'b0;
    case (state_q)
      S_HOLD:  release_now = cnt_hit & stage_ok[idx_q];
      S_STAGE: release_now = stage_ok[idx_q] & ((idx_q == '0) | cnt_hit);
      default: release_now = 1'b0;
    endcase
  end

  assign cnt_target = (state_q == S_HOLD) ? HOLD_T : GAP_T;
  assign cnt_en     = (state_q != S_DONE);
  assign cnt_clr    = accept | release_now | ((state_q == S_HOLD) & cnt_hit);

  rst_seq_cnt #(.W(CW)) u_cnt (
    .clk    (clk),
    .rstn   (rstn_sys),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .target (cnt_target),
    .hit    (cnt_hit)
  );

  always_ff @(posedge clk) begin
    if (!rstn_sys) begin
      state_q     <= S_HOLD;
      idx_q       <= '0;
      req_armed_q <= 1'b0;
    end else begin
      state_q     <= state_nxt;
      idx_q       <= idx_nxt;
      req_armed_q <= ~sw_rst_req;
    end
  end

  always_comb begin
    state_nxt = state_q;
    idx_nxt   = idx_q;
    if (accept) begin
      state_nxt = S_HOLD;
      idx_nxt   = '0;
    end else begin
      case (state_q)
        S_HOLD: begin
          if (cnt_hit) begin
            state_nxt = S_STAGE;
          end
          if (release_now) begin
            if (idx_q == LAST_IDX) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt = idx_q + IW'(1);
            end
          end
        end
        S_STAGE: begin
          if (release_now) begin
            if (idx_q == LAST_IDX) begin
              state_nxt = S_DONE;
            end else begin
              idx_nxt = idx_q + IW'(1);
            end
          end
        end
        default: state_nxt = S_DONE;
      endcase
    end
  end

  always_comb begin
    dom_nxt  = rstn_dom;
    done_nxt = 1'b0;
    ack_nxt  = accept;
    if (accept) begin
      dom_nxt = '0;
    end else begin
      if (release_now) begin
        dom_nxt[idx_q] = 1'b1;
      end
      done_nxt = (state_nxt == S_DONE);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn_sys) begin
      rstn_dom   <= '0;
      sw_rst_ack <= 1'b0;
      rst_done   <= 1'b0;
    end else begin
      rstn_dom   <= dom_nxt;
      sw_rst_ack <= ack_nxt;
      rst_done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_rst_release_seq.sv
// Scoreboard bench: expected output-change events are queued when stimulus is applied
// and matched against every observed change of {ack, done, rstn_dom} on two DUT instances.
module tb_rst_release_seq;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rstn_sys;
  logic       sw_rst_req;
  logic [3:0] stage_ok;
  logic [3:0] rstn_dom;
  logic       sw_rst_ack;
  logic       rst_done;

  logic       sw1;
  logic [0:0] ok1;
  logic [0:0] dom1;
  logic       ack1;
  logic       done1;

  rst_release_seq dut (
    .clk        (clk),
    .rstn_sys   (rstn_sys),
    .sw_rst_req (sw_rst_req),
    .stage_ok   (stage_ok),
    .rstn_dom   (rstn_dom),
    .sw_rst_ack (sw_rst_ack),
    .rst_done   (rst_done)
  );

  rst_release_seq #(.NUM_STAGES(1), .HOLD_CYCLES(1)) dut1 (
    .clk        (clk),
    .rstn_sys   (rstn_sys),
    .sw_rst_req (sw1),
    .stage_ok   (ok1),
    .rstn_dom   (dom1),
    .sw_rst_ack (ack1),
    .rst_done   (done1)
  );

  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         e;
    logic [5:0] v;
  } evt_t;

  evt_t       q[$];
  evt_t       q1[$];
  evt_t       ev;
  evt_t       ev1;
  logic [5:0] exp_last  = '0;
  logic [5:0] exp1_last = '0;
  logic [5:0] prev      = '0;
  logic [5:0] prev1     = '0;
  logic [5:0] obs;
  logic [5:0] obs1;
  bit         mon_en    = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, act, exp, edge_n);
    end
  endtask

  // Events are pushed in time order; a value equal to the last expected one is no change.
  task automatic push(input int e, input logic [5:0] v);
    evt_t x;
    if (v != exp_last) begin
      x.e = e;
      x.v = v;
      q.push_back(x);
      exp_last = v;
    end
  endtask

  task automatic push1(input int e, input logic [5:0] v);
    evt_t x;
    if (v != exp1_last) begin
      x.e = e;
      x.v = v;
      q1.push_back(x);
      exp1_last = v;
    end
  endtask

  // Domain k of the default instance releases 16+8k edges after hold starts at edge c.
  task automatic push_seq(input int c, input int n);
    logic [3:0] m;
    for (int k = 0; k < n; k++) begin
      m = 4'((1 << (k + 1)) - 1);
      push(c + 16 + 8 * k, {1'b0, (k == 3), m});
    end
  endtask

  task automatic wait_until(input int t);
    while (edge_n < t) @(negedge clk);
  endtask

  task automatic do_reset(input int n, output int r);
    int r0;
    r0 = edge_n + 1;
    rstn_sys = 1'b0;
    push(r0, 6'b0);
    push1(r0, 6'b0);
    repeat (n) @(negedge clk);
    rstn_sys = 1'b1;
    r = edge_n;
    push1(r + 1, 6'b000011);
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      obs  = {sw_rst_ack, rst_done, rstn_dom};
      obs1 = {3'b000, ack1, done1, dom1};
      if (obs !== prev) begin
        if (q.size() == 0) begin
          check("extra_evt", 32'(obs), 32'(prev));
        end else begin
          ev = q.pop_front();
          check("evt_edge", edge_n, ev.e);
          check("evt_val", 32'(obs), 32'(ev.v));
        end
        prev = obs;
      end
      if (obs1 !== prev1) begin
        if (q1.size() == 0) begin
          check("extra_evt1", 32'(obs1), 32'(prev1));
        end else begin
          ev1 = q1.pop_front();
          check("evt1_edge", edge_n, ev1.e);
          check("evt1_val", 32'(obs1), 32'(ev1.v));
        end
        prev1 = obs1;
      end
    end
  end

  initial begin
    int r;
    int a;
    rstn_sys   = 1'b0;
    sw_rst_req = 1'b0;
    sw1        = 1'b0;
    stage_ok   = 4'hF;
    ok1        = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_dom", 32'(rstn_dom), 0);
    check("rst_done", 32'(rst_done), 0);
    check("rst_ack", 32'(sw_rst_ack), 0);
    check("rst_dom1", 32'(dom1), 0);
    check("rst_done1", 32'(done1), 0);

    // Power-on sequence; the single-stage instance releases on the first edge.
    mon_en   = 1'b1;
    r        = edge_n;
    rstn_sys = 1'b1;
    push_seq(r, 4);
    push1(r + 1, 6'b000011);
    wait_until(r + 15);
    check("no_early_rel", 32'(rstn_dom), 0);
    wait_until(r + 45);

    // Request held for five cycles while done: exactly one ack and a full rerun.
    sw_rst_req = 1'b1;
    a = edge_n + 1;
    push(a, 6'b100000);
    push(a + 1, 6'b000000);
    push_seq(a, 4);
    repeat (5) @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(a + 45);

    // Domain 2 blocked until edge 50; domain 3 follows one gap later.
    stage_ok = 4'b1011;
    do_reset(1, r);
    push_seq(r, 2);
    wait_until(r + 40);
    check("blocked_dom", 32'(rstn_dom), 32'h3);
    wait_until(r + 49);
    stage_ok = 4'hF;
    push(r + 50, 6'b000111);
    push(r + 58, 6'b011111);
    wait_until(r + 62);

    // Request mid-sequence after two releases restarts the hold.
    do_reset(1, r);
    push_seq(r, 2);
    wait_until(r + 28);
    sw_rst_req = 1'b1;
    a = r + 29;
    push(a, 6'b100000);
    push(a + 1, 6'b000000);
    push_seq(a, 4);
    repeat (2) @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(a + 45);

    // One-cycle reset at offset 30 aborts and restarts from the next edge.
    do_reset(1, r);
    push_seq(r, 2);
    wait_until(r + 29);
    do_reset(1, r);
    push_seq(r, 4);
    wait_until(r + 45);

    // Request held through reset is ignored until it has been seen low.
    sw_rst_req = 1'b1;
    do_reset(3, r);
    push_seq(r, 1);
    wait_until(r + 20);
    check("held_no_ack", 32'(sw_rst_ack), 0);
    sw_rst_req = 1'b0;
    @(negedge clk);
    sw_rst_req = 1'b1;
    a = edge_n + 1;
    push(a, 6'b100000);
    push(a + 1, 6'b000000);
    push_seq(a, 4);
    repeat (3) @(negedge clk);
    sw_rst_req = 1'b0;
    wait_until(a + 45);

    repeat (2) @(negedge clk);
    check("q_left", q.size(), 0);
    check("q1_left", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
